// File: rtl/seg_zext_adder_pkg.sv
// ---------------------------------------------------------------------------
// +-------------------------------------------------------------------------+
// | Module   : seg_zext_adder_pkg                                           |
// | Purpose  : Shared definitions for the segmented zero-extending adder:   |
// |            FSM state encoding and the ceiling-divide helper used to     |
// |            size the segment count (NSEG) and B segment count (NB).      |
// | Ports    : none (package)                                               |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
`default_nettype none

package seg_zext_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage : seg_zext_adder_pkg

`default_nettype wire

// File: rtl/seg_zext_adder_slice.sv
// ---------------------------------------------------------------------------
// +-------------------------------------------------------------------------+
// | Module   : seg_adder_slice                                              |
// | Purpose  : Combinational W-bit adder with carry in / carry out. One     |
// |            instance is time-shared across all segments of an add.      |
// | Ports    : x    in  W  addend segment                                   |
// |            y    in  W  addend segment                                   |
// |            cin  in  1  carry into the segment                           |
// |            s    out W  segment sum                                      |
// |            cout out 1  carry out of the segment                         |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
`default_nettype none

module seg_adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, x} + {1'b0, y} + (W+1)'(cin);

endmodule : seg_adder_slice

`default_nettype wire

// File: rtl/seg_zext_adder.sv
// ---------------------------------------------------------------------------
// +-------------------------------------------------------------------------+
// | Module   : seg_zext_adder                                               |
// | Purpose  : Multi-cycle unsigned adder, sum = a + zero_extend(b),        |
// |            SEG_W bits per cycle, LSB segment first, valid/ready on      |
// |            both sides.                                                  |
// | Ports    : clk        in   1      clock, rising edge                    |
// |            rst        in   1      synchronous active-high reset         |
// |            in_valid   in   1      a/b valid                             |
// |            in_ready   out  1      idle, can accept an operation         |
// |            a          in   A_W    operand A                             |
// |            b          in   B_W    operand B (zero-extended)             |
// |            out_valid  out  1      sum valid                             |
// |            out_ready  in   1      consumer accepts sum                  |
// |            sum        out  A_W+1  {carry_out, a+b}                      |
// | Config   : SEG_ZEXT_ADDER_EARLY_EXIT_EN - finish as soon as all B       |
// |            segments are consumed and no carry is pending.               |
// | Revision : 1.0  initial release                                         |
// +-------------------------------------------------------------------------+
`default_nettype none

module seg_zext_adder
  import seg_zext_adder_pkg::*;
#(
  parameter int A_W   = 40,
  parameter int B_W   = 7,
  parameter int SEG_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [A_W:0]   sum
);

  localparam int NSEG  = ceil_div(A_W, SEG_W);
  localparam int PAD_W = NSEG * SEG_W;
  localparam int IDX_W = $clog2(NSEG + 1);
`ifdef SEG_ZEXT_ADDER_EARLY_EXIT_EN
  localparam int NB    = ceil_div(B_W, SEG_W);
`endif

  generate
    if (B_W < 1 || B_W > A_W) begin : g_bad_bw
      $error("seg_zext_adder: B_W must be in 1..A_W");
    end
  endgenerate

  state_t             state_q, state_d;
  logic [PAD_W-1:0]   a_q, a_d;
  logic [PAD_W-1:0]   b_q, b_d;
  logic [PAD_W-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [SEG_W-1:0]   xseg, yseg, sseg;
  logic               cout;

  // Operand segment selected by the current index.
  always_comb begin
    xseg = '0;
    yseg = '0;
    for (int k = 0; k < NSEG; k++) begin
      if (idx_q == IDX_W'(k)) begin
        xseg = a_q[k*SEG_W +: SEG_W];
        yseg = b_q[k*SEG_W +: SEG_W];
      end
    end
  end

  seg_adder_slice #(.W(SEG_W)) u_slice (
    .x    (xseg),
    .y    (yseg),
    .cin  (carry_q),
    .s    (sseg),
    .cout (cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = PAD_W'(a);
          b_d     = PAD_W'(b);
          // Preload A so that any segments skipped by early exit already
          // hold their final value (B and carry are zero there).
          sum_d   = PAD_W'(a);
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        for (int k = 0; k < NSEG; k++) begin
          if (idx_q == IDX_W'(k)) begin
            sum_d[k*SEG_W +: SEG_W] = sseg;
          end
        end
        carry_d = cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NSEG - 1)) begin
          state_d = DONE;
        end
`ifdef SEG_ZEXT_ADDER_EARLY_EXIT_EN
        else if ((idx_q >= IDX_W'(NB - 1)) && !cout) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  // With a partial top segment the final carry lands inside the padded sum
  // at bit A_W (the slice cout is then always 0); otherwise it is carry_q.
  logic [PAD_W:0] full_sum;
  logic           unused_full_sum;
  assign full_sum        = {carry_q, sum_q};
  assign sum             = full_sum[A_W:0];
  assign unused_full_sum = ^full_sum;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

endmodule : seg_zext_adder

`default_nettype wire
